// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: h/v counters, sync, active flag,
// pixel coordinates, line/frame strobes and a frame-locked, pause-gated game
// tick. All outputs pass through a common 1+PIPE stage register chain so they
// stay aligned with a multi-stage pixel renderer downstream.
module vga_timing_gen #(
  parameter int H_TOTAL  = 800,
  parameter int H_PULSE  = 96,
  parameter int H_BP     = 144,
  parameter int H_FP     = 784,
  parameter int V_TOTAL  = 521,
  parameter int V_PULSE  = 2,
  parameter int V_BP     = 31,
  parameter int V_FP     = 511,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0,
  parameter int PIPE     = 0,
  parameter int TICK_DIV = 1,
  parameter int CW       = 10
) (
  input  logic          dclk,
  input  logic          clr,
  input  logic          en,
  output logic          hsync,
  output logic          vsync,
  output logic          active,
  output logic [CW-1:0] px_x,
  output logic [CW-1:0] px_y,
  output logic          line_start,
  output logic          frame_start,
  output logic          game_tick
);

  // Thresholds are held one bit wider than the counters so that a bound equal
  // to 2^CW (e.g. H_FP == H_TOTAL == 2^CW) still compares correctly.
  localparam logic [CW:0]   H_PULSE_C = H_PULSE[CW:0];
  localparam logic [CW:0]   H_BP_C    = H_BP[CW:0];
  localparam logic [CW:0]   H_FP_C    = H_FP[CW:0];
  localparam logic [CW:0]   V_PULSE_C = V_PULSE[CW:0];
  localparam logic [CW:0]   V_BP_C    = V_BP[CW:0];
  localparam logic [CW:0]   V_FP_C    = V_FP[CW:0];
  localparam int            HL        = H_TOTAL - 1;
  localparam int            VL        = V_TOTAL - 1;
  localparam logic [CW-1:0] H_LAST    = HL[CW-1:0];
  localparam logic [CW-1:0] V_LAST    = VL[CW-1:0];
  localparam logic [CW-1:0] H_BP_N    = H_BP[CW-1:0];
  localparam logic [CW-1:0] V_BP_N    = V_BP[CW-1:0];
  localparam int            TDM       = TICK_DIV - 1;
  localparam logic [7:0]    TD_LAST   = TDM[7:0];

  typedef struct packed {
    logic          hsync;
    logic          vsync;
    logic          active;
    logic [CW-1:0] px_x;
    logic [CW-1:0] px_y;
    logic          line_start;
    logic          frame_start;
    logic          game_tick;
  } vout_t;

  logic [CW-1:0] hc, vc;
  logic [CW:0]   hx, vx;
  logic [7:0]    fcnt;
  logic          fp_evt, tick_a, act;
  vout_t         dec, idle;
  vout_t         pipe [0:PIPE];

  assign hx     = {1'b0, hc};
  assign vx     = {1'b0, vc};
  assign fp_evt = (hc == '0) && (vx == V_FP_C);
  assign tick_a = fp_evt && en && (fcnt == TD_LAST);
  assign act    = (hx >= H_BP_C) && (hx < H_FP_C) && (vx >= V_BP_C) && (vx < V_FP_C);

  // Raster counters: hc free-runs per line, vc advances on each hc wrap.
  always_ff @(posedge dclk) begin
    if (clr) begin
      hc <= '0;
      vc <= '0;
    end else if (hc == H_LAST) begin
      hc <= '0;
      vc <= (vc == V_LAST) ? '0 : vc + 1'b1;
    end else begin
      hc <= hc + 1'b1;
    end
  end

  // Enabled-frame counter, evaluated only at the start of the vertical front porch.
  always_ff @(posedge dclk) begin
    if (clr)
      fcnt <= '0;
    else if (fp_evt && en)
      fcnt <= (fcnt == TD_LAST) ? 8'd0 : fcnt + 8'd1;
  end

  // Inactive output word loaded into every stage on reset.
  always_comb begin
    idle       = '0;
    idle.hsync = ~H_POL;
    idle.vsync = ~V_POL;
  end

  // Combinational decode of the current counter state.
  always_comb begin
    dec             = '0;
    dec.hsync       = (hx < H_PULSE_C) ? H_POL : ~H_POL;
    dec.vsync       = (vx < V_PULSE_C) ? V_POL : ~V_POL;
    dec.active      = act;
    dec.px_x        = act ? hc - H_BP_N : '0;
    dec.px_y        = act ? vc - V_BP_N : '0;
    dec.line_start  = (hc == '0);
    dec.frame_start = (hc == '0) && (vc == '0);
    dec.game_tick   = tick_a;
  end

  // Output register chain: stage 0 registers the decode, PIPE more stages follow.
  always_ff @(posedge dclk) begin
    if (clr) begin
      for (int i = 0; i <= PIPE; i++) pipe[i] <= idle;
    end else begin
      pipe[0] <= dec;
      for (int i = 1; i <= PIPE; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign hsync       = pipe[PIPE].hsync;
  assign vsync       = pipe[PIPE].vsync;
  assign active      = pipe[PIPE].active;
  assign px_x        = pipe[PIPE].px_x;
  assign px_y        = pipe[PIPE].px_y;
  assign line_start  = pipe[PIPE].line_start;
  assign frame_start = pipe[PIPE].frame_start;
  assign game_tick   = pipe[PIPE].game_tick;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: small raster (H 10/2/3/8, V 6/1/2/5,
// 60-cycle frame) at PIPE=0 and PIPE=3, an active-high-polarity variant with
// TICK_DIV=1, and the default 640x480 timing for the first 32 lines.
// Sample index n = posedges since reset release, sampled on the falling edge;
// with PIPE=0 the outputs at n reflect raster position k=n-1.
module tb_vga_timing_gen;
  logic clk = 1'b0;
  logic clr, en;
  always #5 clk = ~clk;

  logic a_hs, a_vs, a_act, a_ls, a_fs, a_tk; logic [9:0] a_x, a_y;
  logic b_hs, b_vs, b_act, b_ls, b_fs, b_tk; logic [9:0] b_x, b_y;
  logic c_hs, c_vs, c_act, c_ls, c_fs, c_tk; logic [9:0] c_x, c_y;
  logic d_hs, d_vs, d_act, d_ls, d_fs, d_tk; logic [9:0] d_x, d_y;

  vga_timing_gen #(.H_TOTAL(10), .H_PULSE(2), .H_BP(3), .H_FP(8), .V_TOTAL(6), .V_PULSE(1),
    .V_BP(2), .V_FP(5), .TICK_DIV(3), .PIPE(0)) u_a (
    .dclk(clk), .clr(clr), .en(en), .hsync(a_hs), .vsync(a_vs), .active(a_act), .px_x(a_x),
    .px_y(a_y), .line_start(a_ls), .frame_start(a_fs), .game_tick(a_tk));
  vga_timing_gen #(.H_TOTAL(10), .H_PULSE(2), .H_BP(3), .H_FP(8), .V_TOTAL(6), .V_PULSE(1),
    .V_BP(2), .V_FP(5), .TICK_DIV(3), .PIPE(3)) u_b (
    .dclk(clk), .clr(clr), .en(en), .hsync(b_hs), .vsync(b_vs), .active(b_act), .px_x(b_x),
    .px_y(b_y), .line_start(b_ls), .frame_start(b_fs), .game_tick(b_tk));
  vga_timing_gen #(.H_TOTAL(10), .H_PULSE(2), .H_BP(3), .H_FP(8), .V_TOTAL(6), .V_PULSE(1),
    .V_BP(2), .V_FP(5), .TICK_DIV(1), .PIPE(0), .H_POL(1'b1), .V_POL(1'b1)) u_c (
    .dclk(clk), .clr(clr), .en(en), .hsync(c_hs), .vsync(c_vs), .active(c_act), .px_x(c_x),
    .px_y(c_y), .line_start(c_ls), .frame_start(c_fs), .game_tick(c_tk));
  vga_timing_gen u_d (
    .dclk(clk), .clr(clr), .en(en), .hsync(d_hs), .vsync(d_vs), .active(d_act), .px_x(d_x),
    .px_y(d_y), .line_start(d_ls), .frame_start(d_fs), .game_tick(d_tk));

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    else n_pass++;
  endtask

  int a_fs_n, a_ls_n, a_hsl, a_vsl, a_act_n, a_tk_n;
  int b_fs_n, b_ls_n, b_hsl, b_vsl, b_act_n, b_tk_n;
  int c_hsh, c_vsh, c_tk_n;
  int d_fs_n, d_ls_n, d_hsl, d_vsl, d_act_n;

  initial begin
    clr = 1'b1; en = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_a_flags", {a_hs, a_vs, a_act, a_ls, a_fs, a_tk}, 6'b110000);
    chk("rst_a_xy", {a_x, a_y}, 0);
    chk("rst_b_flags", {b_hs, b_vs, b_act, b_ls, b_fs, b_tk}, 6'b110000);
    chk("rst_c_sync", {c_hs, c_vs}, 2'b00);
    chk("rst_d_sync", {d_hs, d_vs, d_act}, 3'b110);

    // Phase 1: 8 small frames; en low across the fp events of frames 3 and 4.
    a_fs_n = 0; a_ls_n = 0; a_hsl = 0; a_vsl = 0; a_act_n = 0; a_tk_n = 0;
    b_fs_n = 0; b_ls_n = 0; b_hsl = 0; b_vsl = 0; b_act_n = 0; b_tk_n = 0;
    c_hsh = 0; c_vsh = 0; c_tk_n = 0;
    clr = 1'b0;
    for (int n = 1; n <= 483; n++) begin
      @(negedge clk);
      if (n <= 480) begin
        a_fs_n += a_fs; a_ls_n += a_ls; a_hsl += !a_hs; a_vsl += !a_vs;
        a_act_n += a_act; a_tk_n += a_tk;
        c_hsh += c_hs; c_vsh += c_vs; c_tk_n += c_tk;
      end
      if (n >= 4) begin
        b_fs_n += b_fs; b_ls_n += b_ls; b_hsl += !b_hs; b_vsl += !b_vs;
        b_act_n += b_act; b_tk_n += b_tk;
      end
      if (n <= 3) chk($sformatf("b_quiet_%0d", n), {b_hs, b_vs, b_act, b_ls, b_fs, b_tk}, 6'b110000);
      case (n)
        1: begin
          chk("a_n1", {a_fs, a_ls, a_hs, a_vs, a_act}, 5'b11000);
          chk("c_n1", {c_hs, c_vs}, 2'b11);
        end
        2:  chk("a_n2", {a_fs, a_ls, a_hs}, 3'b000);
        3: begin
          chk("a_hs_end", a_hs, 1'b1);
          chk("c_hs_end", c_hs, 1'b0);
        end
        4:  chk("b_n4", {b_fs, b_ls, b_hs, b_vs}, 4'b1100);
        11: begin
          chk("a_line1", {a_ls, a_fs, a_vs}, 3'b101);
          chk("c_vs_end", c_vs, 1'b0);
        end
        23: chk("a_pre_act", a_act, 1'b0);
        24: chk("a_first_act", {a_act, a_x, a_y}, {1'b1, 10'd0, 10'd0});
        27: chk("b_first_act", {b_act, b_x, b_y}, {1'b1, 10'd0, 10'd0});
        36: chk("a_mid_act", {a_act, a_x, a_y}, {1'b1, 10'd2, 10'd1});
        48: chk("a_last_act", {a_act, a_x, a_y}, {1'b1, 10'd4, 10'd2});
        49: chk("a_post_act", {a_act, a_x}, {1'b0, 10'd0});
        51: chk("b_last_act", {b_act, b_x, b_y}, {1'b1, 10'd4, 10'd2});
        61: chk("a_frame2", a_fs, 1'b1);
        171: chk("a_tick1", a_tk, 1'b1);
        174: chk("b_tick1", b_tk, 1'b1);
        351: chk("a_tick_paused", a_tk, 1'b0);
        471: chk("a_tick2", a_tk, 1'b1);
        474: chk("b_tick2", b_tk, 1'b1);
        default: ;
      endcase
      if (n == 200) en = 1'b0;
      if (n == 320) en = 1'b1;
    end
    chk("a_fs_cnt", a_fs_n, 8);    chk("a_ls_cnt", a_ls_n, 48);
    chk("a_hs_low", a_hsl, 96);    chk("a_vs_low", a_vsl, 80);
    chk("a_act_cnt", a_act_n, 120); chk("a_tk_cnt", a_tk_n, 2);
    chk("b_fs_cnt", b_fs_n, 8);    chk("b_ls_cnt", b_ls_n, 48);
    chk("b_hs_low", b_hsl, 96);    chk("b_vs_low", b_vsl, 80);
    chk("b_act_cnt", b_act_n, 120); chk("b_tk_cnt", b_tk_n, 2);
    chk("c_hs_high", c_hsh, 96);   chk("c_vs_high", c_vsh, 80);
    chk("c_tk_cnt", c_tk_n, 6);

    // Phase 2: fresh start, two fp events (fcnt=2), then clr mid-active.
    clr = 1'b1;
    repeat (2) @(negedge clk);
    clr = 1'b0;
    for (int n = 1; n <= 156; n++) @(negedge clk);
    chk("a_pre_clr_act", {a_act, a_x, a_y}, {1'b1, 10'd2, 10'd1});
    clr = 1'b1;
    @(negedge clk);
    chk("a_clr_mid", {a_hs, a_vs, a_act, a_ls, a_fs, a_tk}, 6'b110000);
    chk("b_clr_mid", {b_hs, b_vs, b_act, b_ls, b_fs, b_tk}, 6'b110000);
    clr = 1'b0;
    a_tk_n = 0;
    for (int n = 1; n <= 180; n++) begin
      @(negedge clk);
      a_tk_n += a_tk;
      case (n)
        1:   chk("a_rel_fs", a_fs, 1'b1);
        4:   chk("b_rel_fs", b_fs, 1'b1);
        51:  chk("a_no_stale_tick", a_tk, 1'b0);
        171: chk("a_rel_tick", a_tk, 1'b1);
        default: ;
      endcase
    end
    chk("a_rel_tk_cnt", a_tk_n, 1);

    // Phase 3: default 640x480 timing through line 31 (first visible line).
    clr = 1'b1;
    repeat (2) @(negedge clk);
    clr = 1'b0;
    d_fs_n = 0; d_ls_n = 0; d_hsl = 0; d_vsl = 0; d_act_n = 0;
    for (int n = 1; n <= 25600; n++) begin
      @(negedge clk);
      d_fs_n += d_fs; d_ls_n += d_ls; d_vsl += !d_vs; d_act_n += d_act;
      if (n <= 800) d_hsl += !d_hs;
      case (n)
        1:     chk("d_n1", {d_fs, d_ls, d_hs, d_vs}, 4'b1100);
        97:    chk("d_hs_end", d_hs, 1'b1);
        800:   chk("d_ls_pre", d_ls, 1'b0);
        801:   chk("d_ls_line1", {d_ls, d_fs}, 2'b10);
        1601:  chk("d_vs_end", d_vs, 1'b1);
        24944: chk("d_pre_act", d_act, 1'b0);
        24945: chk("d_first_act", {d_act, d_x, d_y}, {1'b1, 10'd0, 10'd0});
        25584: chk("d_last_col", {d_act, d_x, d_y}, {1'b1, 10'd639, 10'd0});
        25585: chk("d_post_act", {d_act, d_x}, {1'b0, 10'd0});
        default: ;
      endcase
    end
    chk("d_fs_cnt", d_fs_n, 1);   chk("d_ls_cnt", d_ls_n, 32);
    chk("d_hs_low", d_hsl, 96);   chk("d_vs_low", d_vsl, 1600);
    chk("d_act_cnt", d_act_n, 640);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA raster timing generator; the successor to the fixed 640x480 counter/sync logic currently embedded in the game top.
- Generates the h/v counters, sync pulses, the active-video flag and pixel coordinates.
- Also generates per-line and per-frame strobes, plus a frame-locked, pause-gated game tick that replaces free-running clock-count dividers.
- Includes a configurable output pipeline so sync and blanking stay aligned with a multi-stage pixel renderer downstream.

Parameters:
- H_TOTAL, 800: pixel clocks per line.
- H_PULSE, 96: hsync pulse length; the pulse occupies hc in [0, H_PULSE).
- H_BP, 144: first active column (end of back porch).
- H_FP, 784: first column after active video (start of front porch).
- V_TOTAL, 521: lines per frame.
- V_PULSE, 2: vsync pulse length in lines; the pulse occupies vc in [0, V_PULSE).
- V_BP, 31: first active line.
- V_FP, 511: first line after active video.
- H_POL, 0: hsync asserted level (0 = active-low).
- V_POL, 0: vsync asserted level (0 = active-low).
- PIPE, 0: extra output delay stages (0..7).
- TICK_DIV, 1: frames per game_tick (1..255).
- CW, 10: width of counters and coordinates.
- Legal configurations require H_PULSE < H_BP < H_FP <= H_TOTAL <= 2^CW, and the same ordering for V.

Ports:
- dclk, input, 1: pixel clock. The only clock.
- clr, input, 1: reset, synchronous, active-high.
- en, input, 1: game enable (low = paused). Gates game_tick only; raster timing never stops.
- hsync, output, 1: horizontal sync at H_POL when asserted.
- vsync, output, 1: vertical sync at V_POL when asserted.
- active, output, 1: high inside the visible region.
- px_x, output, CW: column within the visible region, 0..H_FP-H_BP-1. Value is 0 when active=0.
- px_y, output, CW: row within the visible region, 0..V_FP-V_BP-1. Value is 0 when active=0.
- line_start, output, 1: one-cycle pulse at hc==0.
- frame_start, output, 1: one-cycle pulse at hc==0 && vc==0.
- game_tick, output, 1: one-cycle pulse at the start of the vertical front porch every TICK_DIV enabled frames.

Behaviour:
- Counters:
  - hc counts 0..H_TOTAL-1 and wraps to 0.
  - vc increments only on the hc wrap. vc counts 0..V_TOTAL-1 and wraps to 0 on the cycle where both counters wrap.
- Decode, from the current (hc, vc):
  - hs_a = hc < H_PULSE
  - vs_a = vc < V_PULSE
  - act = H_BP <= hc < H_FP && V_BP <= vc < V_FP
  - px_x = act ? hc-H_BP : 0
  - px_y = act ? vc-V_BP : 0
- Output sync levels: hsync = hs_a ? H_POL : ~H_POL. vsync follows the same rule with vs_a and V_POL.
- Latency: every output is registered. Each output reflects the counter state from exactly 1+PIPE cycles earlier. All outputs share the same delay, so they stay mutually aligned.
- Frame counter:
  - fcnt is 8 bits. It is evaluated on the cycle where hc==0 && vc==V_FP (the "fp event").
  - At an fp event with en=1: if fcnt==TICK_DIV-1, tick_a=1 and fcnt<=0. Otherwise fcnt<=fcnt+1.
  - At an fp event with en=0: fcnt is held and no tick is produced.
  - tick_a enters the same 1+PIPE pipeline as the other outputs.
  - en is sampled only at fp events. en toggling mid-frame has no other effect.
- Reset, on a dclk edge with clr=1:
  - hc=0, vc=0, fcnt=0.
  - All pipeline stages clear to: hsync=~H_POL, vsync=~V_POL, active=0, px_x=0, px_y=0, all strobes 0.
- After reset release:
  - Counting starts from (0,0) on the first edge with clr=0.
  - The first frame_start and the first hsync assertion appear 1+PIPE cycles after that edge.
  - Pipeline stages that still hold reset values output the inactive values above. No spurious strobes are produced.
- Reset mid-frame: the same behaviour applies. The partial frame is abandoned, no tick is emitted for it, and fcnt restarts at 0.
- Coincident events: frame_start and line_start assert together at (0,0). game_tick never coincides with frame_start, because V_FP != 0.
- clr has priority over counting and over en.

Test Plan:
- Default parameters, release clr, run 2 frames:
  - frame_start period is 416800 cycles and line_start period is 800.
  - hsync is low for 96 cycles per line. vsync is low for 1600 cycles per frame.
  - active is high for 307200 cycles per frame.
- Default parameters, PIPE=0: the first frame_start occurs 1 cycle after reset release. In the first active cycle of each frame, px_x=0 and px_y=0. In the last active cycle, px_x=639 and px_y=479.
- PIPE=3 with the same stimulus: every output is an exact 3-cycle-delayed copy of the PIPE=0 run. No output toggles during the first 4 post-reset cycles except as dictated by that delayed copy.
- Small config, H 10/2/3/8, V 6/1/2/5, TICK_DIV=3:
  - With en=1 throughout, game_tick fires once every 3 frames at hc=0, vc=5, +1 cycle.
  - Drop en for 2 fp events and the next tick is delayed by exactly 2 frames.
- H_POL=1, V_POL=1: hsync and vsync are high only during their pulses. After reset they are held low.
- Assert clr for 1 cycle in mid-active video (vc=200): on the next cycle, active=0 and hc/vc restart at 0. The next frame_start arrives 1+PIPE cycles after release, and fcnt restarts at 0, so the first tick follows TICK_DIV full fp events later.
